// File: rtl/bram_sp_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : bram_sp_ctrl
// Purpose  : Single-port inferred block-RAM controller with byte-enable writes,
//            valid/ready requests, fixed-latency responses and a post-reset
//            clear sweep. Define BRAM_OUT_REG_EN for an extra output register
//            stage (response latency 2 instead of 1).
// Revision : 1.0 - initial release
//==============================================================================
module bram_sp_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] c_LAST        = {ADDR_W{1'b1}};
    localparam logic              c_WRITE_FIRST = (RDW_MODE == 0);
    localparam logic              c_NO_CHANGE   = (RDW_MODE == 2);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_nxt;
    logic                r_ready;
    logic                r_init_done;
    logic                w_ready_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rsp_word;
    logic                w_accept;
    logic                w_rsp_fire;

    logic                r_v1;
    logic [DATA_W-1:0]   r_d1;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_nxt;
            r_ready     <= w_ready_nxt;
            r_init_done <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_clr_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
        // Ready/init_done are registered so they rise together on the first IDLE cycle
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign w_accept  = req_valid & r_ready;

    // ---------------------------------------------------------------- array
    assign w_rd_word = mem[req_addr];

    always_comb begin
        w_merged = w_rd_word;
        for (int i = 0; i < NB; i++) begin
            if (req_be[i]) begin
                w_merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    // Storage has no reset; the sweep owns the write port while in CLEAR
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            mem[r_clr_cnt] <= '0;
        end else if (w_accept && req_we) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------- response
    assign w_rsp_fire = w_accept & ~(req_we & c_NO_CHANGE);
    assign w_rsp_word = (req_we && c_WRITE_FIRST) ? w_merged : w_rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_d1 <= w_rsp_word;
            end
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic                r_v2;
    logic [DATA_W-1:0]   r_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
        end else begin
            r_v2 <= r_v1;
            r_d2 <= r_d1;
        end
    end

    assign rsp_valid = r_v2;
    assign rsp_rdata = r_d2;
`else
    assign rsp_valid = r_v1;
    assign rsp_rdata = r_d1;
`endif

endmodule
`default_nettype wire
